barrel_math_pipe: RTL and testbench

- Parametrised successor of the barrel-distortion address engine: raster generator, radial-scale pipeline and address mapper, with full valid/ready backpressure.
- Streams centred pixel coordinates to the cartesian-to-polar core (tIn).
- Scales the returned radius by 1 ± k·r², with mode and k run-time selectable, and sends it to the polar-to-cartesian core (rCin/rPin).
- Clamps the rotated result (rOut) into frame-buffer x/y addresses.

---
 rtl/barrel_math_pipe.sv | 194 +++++++++++++++++++
 tb/tb_barrel_math_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_math_pipe.sv
// Barrel-distortion address engine: raster generator feeding the cart-to-polar core,
// a 6-stage radial scale pipeline (1 +/- k*r^2), and a clamping frame-buffer address mapper.
module barrel_math_pipe #(
  parameter int H_RES   = 1080,
  parameter int V_RES   = 960,
  parameter int COORD_W = 12,
  parameter int FRAC_W  = 3,
  parameter int K_SHIFT = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gen_en,
  input  logic [1:0]         mode,
  input  logic [15:0]        k_coef,
  output logic [31:0]        tIn_tdata,
  output logic               tIn_tvalid,
  input  logic               tIn_tready,
  input  logic [31:0]        tOut_tdata,
  input  logic               tOut_tvalid,
  output logic               tOut_tready,
  output logic [31:0]        rCin_tdata,
  output logic [15:0]        rPin_tdata,
  output logic               rCin_tvalid,
  output logic               rPin_tvalid,
  input  logic               rCin_tready,
  input  logic               rPin_tready,
  input  logic [31:0]        rOut_tdata,
  input  logic               rOut_tvalid,
  output logic               rOut_tready,
  output logic [COORD_W-1:0] xOut,
  output logic [COORD_W-1:0] yOut,
  output logic               addr_vld,
  input  logic               mem_ready,
  output logic               clipped,
  output logic               frame_done
);

  // All streams use valid/ready: a beat transfers on a cycle where both are high;
  // a producer holds data stable while valid is high and ready is low.

  localparam logic signed [COORD_W-1:0] X_MIN = COORD_W'(-(H_RES / 2));
  localparam logic signed [COORD_W-1:0] X_MAX = COORD_W'(H_RES / 2 - 1);
  localparam logic signed [COORD_W-1:0] Y_TOP = COORD_W'(V_RES / 2);
  localparam logic signed [COORD_W-1:0] Y_BOT = COORD_W'(-(V_RES / 2) + 1);

  // ---------------- raster generator ----------------
  logic signed [COORD_W-1:0] gx, gy;
  logic [15:0] gx16, gy16;
  logic        gen_hs, last_col, last_row;

  assign gen_hs    = tIn_tvalid & tIn_tready;
  assign last_col  = (gx == X_MAX);
  assign last_row  = (gy == Y_BOT);
  assign gx16      = {{(16 - COORD_W){gx[COORD_W-1]}}, gx} << FRAC_W;
  assign gy16      = {{(16 - COORD_W){gy[COORD_W-1]}}, gy} << FRAC_W;
  assign tIn_tdata = {gy16, gx16};

  always_ff @(posedge clk) begin
    if (reset) begin
      gx         <= X_MIN;
      gy         <= Y_TOP;
      tIn_tvalid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= gen_hs & last_col & last_row;
      if (!tIn_tvalid || tIn_tready) tIn_tvalid <= gen_en;
      if (gen_hs) begin
        if (last_col) begin
          gx <= X_MIN;
          gy <= last_row ? Y_TOP : gy - COORD_W'(1);
        end else begin
          gx <= gx + COORD_W'(1);
        end
      end
    end
  end

  // ---------------- radial scale pipeline ----------------
  logic        en;
  logic        v1, v2, v3, v4, v5, v6;
  logic [15:0] r1, r2, r3, r4;
  logic [15:0] ph1, ph2, ph3, ph4, ph5, ph6;
  logic [1:0]  m1, m2, m3;
  logic [15:0] k1, k2;
  logic [31:0] sq2;
  logic [14:0] d3, scale4;
  logic [30:0] p5;
  logic [15:0] rout6;

  logic [31:0] sq_n;
  logic [47:0] prod_n, sh_n;
  logic [14:0] d_n, scale_n;
  logic [15:0] add_n;
  logic [30:0] p_n, q_n;
  logic [15:0] rout_n;

  assign en          = ~v6 | (rCin_tready & rPin_tready);
  assign tOut_tready = en;
  assign rCin_tdata  = {16'b0, rout6};
  assign rPin_tdata  = ph6;
  assign rCin_tvalid = v6;
  assign rPin_tvalid = v6;

  always_comb begin
    sq_n    = 32'(r1) * 32'(r1);
    prod_n  = 48'(sq2) * 48'(k2);
    sh_n    = prod_n >> K_SHIFT;
    d_n     = (sh_n > 48'd32767) ? 15'h7FFF : sh_n[14:0];
    add_n   = 16'd16384 + {1'b0, d3};
    scale_n = 15'd16384;
    case (m3)
      2'd1:    scale_n = (add_n > 16'd32767) ? 15'h7FFF : add_n[14:0];
      2'd2:    scale_n = ({1'b0, d3} > 16'd16384) ? 15'd0 : 15'(16'd16384 - {1'b0, d3});
      default: scale_n = 15'd16384;
    endcase
    p_n    = 31'(r4) * 31'(scale4);
    q_n    = p5 >> 14;
    rout_n = (q_n > 31'h0000_FFFF) ? 16'hFFFF : q_n[15:0];
  end

  // Data registers load on every enabled cycle; valids mark which stages hold real samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      {v1, v2, v3, v4, v5, v6} <= '0;
      {r1, r2, r3, r4}         <= '0;
      {ph1, ph2, ph3, ph4, ph5, ph6} <= '0;
      {m1, m2, m3}             <= '0;
      {k1, k2}                 <= '0;
      sq2    <= '0;
      d3     <= '0;
      scale4 <= '0;
      p5     <= '0;
      rout6  <= '0;
    end else if (en) begin
      v1 <= tOut_tvalid; r1 <= tOut_tdata[15:0]; ph1 <= tOut_tdata[31:16];
      m1 <= mode;        k1 <= k_coef;
      v2 <= v1; r2 <= r1; ph2 <= ph1; m2 <= m1; k2 <= k1; sq2 <= sq_n;
      v3 <= v2; r3 <= r2; ph3 <= ph2; m3 <= m2; d3 <= d_n;
      v4 <= v3; r4 <= r3; ph4 <= ph3; scale4 <= scale_n;
      v5 <= v4; ph5 <= ph4; p5 <= p_n;
      v6 <= v5; ph6 <= ph5; rout6 <= rout_n;
    end
  end

  // ---------------- address mapper ----------------
  localparam logic signed [16:0] H_HALF = 17'(H_RES / 2);
  localparam logic signed [16:0] V_HALF = 17'(V_RES / 2);
  localparam logic signed [16:0] H_MAX  = 17'(H_RES - 1);
  localparam logic signed [16:0] V_MAX  = 17'(V_RES - 1);

  logic signed [16:0] rxe, rye, xa, ya;
  logic [COORD_W-1:0] xc, yc;
  logic               clip_n, load;

  assign rOut_tready = ~addr_vld | mem_ready;
  assign load        = rOut_tvalid & rOut_tready;

  always_comb begin
    rxe    = {rOut_tdata[15], rOut_tdata[15:0]};
    rye    = {rOut_tdata[31], rOut_tdata[31:16]};
    xa     = (rxe >>> FRAC_W) + H_HALF;
    ya     = V_HALF - (rye >>> FRAC_W);
    clip_n = 1'b0;
    xc     = xa[COORD_W-1:0];
    yc     = ya[COORD_W-1:0];
    if (xa < 0) begin
      xc = '0; clip_n = 1'b1;
    end else if (xa > H_MAX) begin
      xc = H_MAX[COORD_W-1:0]; clip_n = 1'b1;
    end
    if (ya < 0) begin
      yc = '0; clip_n = 1'b1;
    end else if (ya > V_MAX) begin
      yc = V_MAX[COORD_W-1:0]; clip_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_vld <= 1'b0;
      xOut     <= '0;
      yOut     <= '0;
      clipped  <= 1'b0;
    end else if (load) begin
      addr_vld <= 1'b1;
      xOut     <= xc;
      yOut     <= yc;
      clipped  <= clip_n;
    end else if (mem_ready) begin
      addr_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_barrel_math_pipe.sv
// Directed bench for barrel_math_pipe: raster order, frame wrap (small instance),
// scale arithmetic/saturation, backpressure ordering and address clamping.
module tb_barrel_math_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, gen_en, tIn_tready, tOut_tvalid, rCin_tready, rPin_tready;
  logic        rOut_tvalid, mem_ready;
  logic [1:0]  mode;
  logic [15:0] k_coef;
  logic [31:0] tOut_tdata, rOut_tdata;
  logic [31:0] tIn_tdata, rCin_tdata;
  logic [15:0] rPin_tdata;
  logic        tIn_tvalid, tOut_tready, rCin_tvalid, rPin_tvalid, rOut_tready;
  logic [11:0] xOut, yOut;
  logic        addr_vld, clipped, frame_done;

  barrel_math_pipe dut (
    .clk(clk), .reset(reset), .gen_en(gen_en), .mode(mode), .k_coef(k_coef),
    .tIn_tdata(tIn_tdata), .tIn_tvalid(tIn_tvalid), .tIn_tready(tIn_tready),
    .tOut_tdata(tOut_tdata), .tOut_tvalid(tOut_tvalid), .tOut_tready(tOut_tready),
    .rCin_tdata(rCin_tdata), .rPin_tdata(rPin_tdata),
    .rCin_tvalid(rCin_tvalid), .rPin_tvalid(rPin_tvalid),
    .rCin_tready(rCin_tready), .rPin_tready(rPin_tready),
    .rOut_tdata(rOut_tdata), .rOut_tvalid(rOut_tvalid), .rOut_tready(rOut_tready),
    .xOut(xOut), .yOut(yOut), .addr_vld(addr_vld), .mem_ready(mem_ready),
    .clipped(clipped), .frame_done(frame_done)
  );

  // Small-frame instance so a whole frame fits in a short run.
  logic        s_gen_en, s_tIn_tvalid, s_tOut_tready, s_rCin_tvalid, s_rPin_tvalid;
  logic        s_rOut_tready, s_addr_vld, s_clipped, s_frame_done;
  logic [31:0] s_tIn_tdata, s_rCin_tdata;
  logic [15:0] s_rPin_tdata;
  logic [11:0] s_xOut, s_yOut;

  barrel_math_pipe #(.H_RES(8), .V_RES(4)) dut_small (
    .clk(clk), .reset(reset), .gen_en(s_gen_en), .mode(2'd0), .k_coef(16'd0),
    .tIn_tdata(s_tIn_tdata), .tIn_tvalid(s_tIn_tvalid), .tIn_tready(1'b1),
    .tOut_tdata(32'd0), .tOut_tvalid(1'b0), .tOut_tready(s_tOut_tready),
    .rCin_tdata(s_rCin_tdata), .rPin_tdata(s_rPin_tdata),
    .rCin_tvalid(s_rCin_tvalid), .rPin_tvalid(s_rPin_tvalid),
    .rCin_tready(1'b1), .rPin_tready(1'b1),
    .rOut_tdata(32'd0), .rOut_tvalid(1'b0), .rOut_tready(s_rOut_tready),
    .xOut(s_xOut), .yOut(s_yOut), .addr_vld(s_addr_vld), .mem_ready(1'b1),
    .clipped(s_clipped), .frame_done(s_frame_done)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_xy(input int x, input int y);
    logic [15:0] xs, ys;
    xs = 16'(x * 8);
    ys = 16'(y * 8);
    return {ys, xs};
  endfunction

  function automatic logic [15:0] scale_model(input logic [15:0] r, input logic [1:0] m,
                                              input logic [15:0] k);
    longint r2, d, s, q;
    r2 = longint'(r) * longint'(r);
    d  = (r2 * longint'(k)) >>> 24;
    if (d > 32767) d = 32767;
    if (m == 2'd1)      s = 16384 + d;
    else if (m == 2'd2) s = 16384 - d;
    else                s = 16384;
    if (s < 0) s = 0;
    if (s > 32767) s = 32767;
    q = (longint'(r) * s) >>> 14;
    if (q > 65535) q = 65535;
    return 16'(q);
  endfunction

  task automatic scale_vec(input string tag, input logic [15:0] r, input logic [1:0] m,
                           input logic [15:0] k, input logic [15:0] ph, input logic [31:0] exp);
    @(negedge clk);
    mode = m; k_coef = k; tOut_tdata = {ph, r}; tOut_tvalid = 1'b1;
    rCin_tready = 1'b1; rPin_tready = 1'b1;
    #1 check({tag, "_tready"}, 32'(tOut_tready), 32'd1);
    @(negedge clk);
    tOut_tvalid = 1'b0;
    mode = (m == 2'd2) ? 2'd1 : 2'd2;
    k_coef = 16'h1234;
    repeat (4) @(negedge clk);
    check({tag, "_early"}, 32'(rCin_tvalid), 32'd0);
    @(negedge clk);
    check({tag, "_vld"}, 32'({rCin_tvalid, rPin_tvalid}), 32'd3);
    check({tag, "_data"}, rCin_tdata, exp);
    check({tag, "_phase"}, 32'(rPin_tdata), 32'(ph));
  endtask

  task automatic addr_beat(input string tag, input int x, input int y,
                           input int ex, input int ey, input int ec);
    rOut_tdata = {16'(y), 16'(x)};
    rOut_tvalid = 1'b1;
    @(negedge clk);
    check({tag, "_vld"}, 32'(addr_vld), 32'd1);
    check({tag, "_x"}, 32'(xOut), 32'(ex));
    check({tag, "_y"}, 32'(yOut), 32'(ey));
    check({tag, "_clip"}, 32'(clipped), 32'(ec));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, pulses, sent, got_n, fd_seen;
    bit seen, pending;

    reset = 1'b1; gen_en = 1'b0; tIn_tready = 1'b0; mode = 2'd0; k_coef = 16'd0;
    tOut_tdata = '0; tOut_tvalid = 1'b0; rCin_tready = 1'b1; rPin_tready = 1'b1;
    rOut_tdata = '0; rOut_tvalid = 1'b0; mem_ready = 1'b0; s_gen_en = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_tin_vld", 32'(tIn_tvalid), 32'd0);
    check("rst_tin_data", tIn_tdata, 32'h0F00_EF20);
    check("rst_rc_vld", 32'(rCin_tvalid), 32'd0);
    check("rst_rc_data", rCin_tdata, 32'd0);
    check("rst_addr", 32'({addr_vld, clipped, frame_done}), 32'd0);
    check("rst_xy", 32'({xOut, yOut}), 32'd0);
    check("rst_readies", 32'({tOut_tready, rOut_tready}), 32'd3);

    // raster order across the first row
    reset = 1'b0; gen_en = 1'b1; tIn_tready = 1'b1;
    fd_seen = 0;
    for (int i = 0; i <= 1080; i++) begin
      @(negedge clk);
      if (frame_done) fd_seen++;
      if (i == 0 || i == 1 || i == 539 || i == 1079 || i == 1080) begin
        check($sformatf("raster_vld_%0d", i), 32'(tIn_tvalid), 32'd1);
        check($sformatf("raster_%0d", i), tIn_tdata, pack_xy(-540 + (i % 1080), 480 - i / 1080));
      end
    end
    check("raster_no_frame_done", 32'(fd_seen), 32'd0);

    // beat held while not ready, regardless of gen_en
    tIn_tready = 1'b0; gen_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("hold_vld", 32'(tIn_tvalid), 32'd1);
      check("hold_data", tIn_tdata, pack_xy(-540, 479));
    end
    tIn_tready = 1'b1;
    @(negedge clk);
    check("hold_release", 32'(tIn_tvalid), 32'd0);
    check("hold_advance", tIn_tdata, pack_xy(-539, 479));

    // full frame on the 8x4 instance
    s_gen_en = 1'b1;
    hs = 0; seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (s_frame_done) seen = 1'b1;
      else if (s_tIn_tvalid) hs++;
    end
    check("frame_seen", 32'(seen), 32'd1);
    check("frame_beats", 32'(hs), 32'd32);
    check("frame_wrap", s_tIn_tdata, pack_xy(-4, 2));
    s_gen_en = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_frame_done) pulses++;
    end
    check("frame_single_pulse", 32'(pulses), 32'd0);

    // scale arithmetic and saturation
    scale_vec("add_800", 16'd800, 2'd1, 16'd2621, 16'h1111, 32'd804);
    scale_vec("sub_800", 16'd800, 2'd2, 16'd2621, 16'h2222, 32'd795);
    scale_vec("byp_800", 16'd800, 2'd0, 16'd2621, 16'h3333, 32'd800);
    scale_vec("m3_800", 16'd800, 2'd3, 16'd2621, 16'h4444, 32'd800);
    scale_vec("sat_add", 16'hFFFF, 2'd1, 16'hFFFF, 16'h5555, 32'h0000_FFFF);
    scale_vec("sat_sub", 16'hFFFF, 2'd2, 16'hFFFF, 16'h6666, 32'd0);
    @(negedge clk);

    // streaming with a 10-cycle output stall
    mode = 2'd1; k_coef = 16'd2621;
    sent = 0; got_n = 0; pending = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 300 && got_n < 20; cyc++) begin
      @(negedge clk);
      rCin_tready = !(cyc >= 8 && cyc < 18);
      rPin_tready = rCin_tready;
      if (sent < 20 && (pending || (cyc % 7) != 3)) begin
        tOut_tvalid = 1'b1;
        tOut_tdata = {16'(sent), 16'(800 + 50 * sent)};
      end else begin
        tOut_tvalid = 1'b0;
      end
      #1;
      if (rCin_tvalid && !rCin_tready) check("stall_tready", 32'(tOut_tready), 32'd0);
      if (rCin_tvalid && rCin_tready) begin
        if (exp_q.size() == 0) check("sb_extra", 32'd1, 32'd0);
        else check("sb_data", {rPin_tdata, rCin_tdata[15:0]}, exp_q.pop_front());
        got_n++;
      end
      pending = tOut_tvalid && !tOut_tready;
      if (tOut_tvalid && tOut_tready) begin
        exp_q.push_back({16'(sent), scale_model(16'(800 + 50 * sent), 2'd1, 16'd2621)});
        sent++;
      end
    end
    @(negedge clk);
    tOut_tvalid = 1'b0; rCin_tready = 1'b1; rPin_tready = 1'b1;
    check("sb_count", 32'(got_n), 32'd20);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    // address mapper: clamp and hold under mem_ready=0
    rOut_tdata = {16'd0, 16'(-5000)}; rOut_tvalid = 1'b1; mem_ready = 1'b0;
    #1 check("map_ready0", 32'(rOut_tready), 32'd1);
    @(negedge clk);
    rOut_tvalid = 1'b0;
    check("clip_vld", 32'(addr_vld), 32'd1);
    check("clip_x", 32'(xOut), 32'd0);
    check("clip_y", 32'(yOut), 32'd480);
    check("clip_flag", 32'(clipped), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("hold_addr", {8'd0, addr_vld, clipped, xOut, yOut[9:0]}, {8'd0, 1'b1, 1'b1, 12'd0, 10'd480});
      check("hold_tready", 32'(rOut_tready), 32'd0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("drain_vld", 32'(addr_vld), 32'd0);

    // back-to-back beats with mem_ready held high
    addr_beat("in",    800,   -640, 640, 560, 0);
    addr_beat("xmax",  4312,  0,    1079, 480, 0);
    addr_beat("xmin",  -4320, 0,    0,   480, 0);
    addr_beat("xhi",   24000, 0,    1079, 480, 1);
    addr_beat("ylo",   0,     -3832, 540, 959, 0);
    addr_beat("yclip", 0,     -3840, 540, 959, 1);
    addr_beat("ytop",  0,     4800, 540, 0,   1);
    addr_beat("yzero", 0,     3840, 540, 0,   0);
    addr_beat("frac",  -1,    7,    539, 480, 0);
    rOut_tvalid = 1'b0;
    @(negedge clk);
    check("end_vld", 32'(addr_vld), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
